reg_readback_tx: RTL and testbench
==================================

# reg_readback_tx

Read-back sequencer that shares the register block's read port and the UART transmitter between read requests. On each accepted request it issues one register read, captures the returned word and streams a response frame through `uart_tx`. The frame is a header byte, the address byte, then the value bytes MSB first. It sits beside `command_parser_uart`, which raises read requests, and closes the loop so a host can verify writes made over the same link.

## Interface
Parameters:
- `WORD_WIDTH`, 8: byte and address width in bits.
- `VALUE_WORDS`, 4: bytes per register value; register width is `WORD_WIDTH*VALUE_WORDS`.
- `READ_LATENCY`, 1: clock edges from the `o_r_en` cycle to `i_r_data` being valid; must be ≥ 1.
- `RESP_HEADER`, 8'h02: first byte of every response frame.

Ports:
- `clk`  in  1  single clock for all logic.
- `i_reset`  in  1  reset, synchronous and active-high.
- `i_req`  in  1  read request valid.
- `i_req_addr`  in  `WORD_WIDTH`  register address to read.
- `o_req_ready`  out  1  high only in IDLE; a request is accepted on an edge with `i_req & o_req_ready`.
- `o_r_en`  out  1  register read enable, one-cycle pulse.
- `o_r_addr`  out  `WORD_WIDTH`  register read address.
- `i_r_data`  in  `WORD_WIDTH*VALUE_WORDS`  register read value.
- `o_tx_data`  out  `WORD_WIDTH`  byte to `uart_tx`.
- `o_tx_dv`  out  1  `uart_tx` data-valid, one-cycle pulse.
- `i_tx_busy`  in  1  `uart_tx` busy.
- `o_busy`  out  1  high whenever state ≠ IDLE.

## Operation
- All outputs are registered.
- Reset values:
  - `o_req_ready` = 1 and `o_busy` = 0.
  - `o_r_en`, `o_tx_dv`, `o_tx_data` and `o_r_addr` = 0.
  - State = IDLE, byte counter = 0, shift register = 0.
- States:
  - IDLE: on an accepted request, latch `i_req_addr`, then → READ.
  - READ: `o_r_en` = 1 for the first cycle only, with `o_r_addr` = latched address. A latency counter runs `READ_LATENCY` edges, then → LOAD.
  - LOAD: load the shift register with {`RESP_HEADER`, addr, `i_r_data`}. Byte counter = `VALUE_WORDS`+2. → SEND.
  - SEND: only when `i_tx_busy` = 0, drive `o_tx_dv` = 1 for one cycle with `o_tx_data` = top byte. Then → WAIT_HI. If `i_tx_busy` = 1, hold in SEND.
  - WAIT_HI: wait for `i_tx_busy` = 1, which is the transmitter's acceptance, then → WAIT_LO.
  - WAIT_LO: wait for `i_tx_busy` = 0. Then shift left by `WORD_WIDTH` and decrement the counter. If the counter reaches 0 → IDLE, else → SEND.
- Frame length is `VALUE_WORDS`+2 bytes. The counter width is `$clog2(VALUE_WORDS+3)`.
- Requests arriving while busy are not accepted and not queued; the requester holds `i_req`.
- `i_r_data` is sampled only in LOAD. Register writes after that edge do not alter the frame in flight.
- Reset mid-frame:
  - Returns to IDLE on the next edge and the frame is abandoned.
  - `o_tx_dv` goes low the same edge; a byte already inside `uart_tx` completes there.
  - `o_req_ready` is 1 after that edge.
- `i_reset` has priority over a simultaneous request.

## Timing
- Edge 0 accepts the request. Cycle 1: `o_r_en` = 1.
- Data is captured at edge 1+`READ_LATENCY`; LOAD follows. The first `o_tx_dv` is at the earliest 2 cycles after that, if `i_tx_busy` is low.
- One byte costs `o_tx_dv` plus the full `uart_tx` busy window plus two cycles of handshake overhead.
- Back-to-back frames: `o_req_ready` rises the cycle after the last WAIT_LO exit. The next request is accepted on the following edge.
- `o_tx_dv` is never asserted while `i_tx_busy` = 1.
- `o_r_en` is never asserted outside the first READ cycle.

## Structure
- Package `reg_readback_pkg`:
  - state enum (IDLE, READ, LOAD, SEND, WAIT_HI, WAIT_LO);
  - default `RESP_HEADER` constant;
  - frame-length function `VALUE_WORDS`+2.
- No sub-module: a single FSM with shift register and counters.
- The top level instantiates this block next to `command_parser_uart`, `register_block` and `uart_tx`.

## Test plan
- Write 32'hbbb00b00 to address 8'h12 via the parser, then request address 8'h12. Required: the UART line decodes 02 12 bb b0 0b 00 and `o_r_en` pulses exactly once.
- Default parameters, `READ_LATENCY` = 2, stub register returns 32'h12345678 for address 8'hff. Required: frame 02 ff 12 34 56 78, with data captured on the second edge after `o_r_en`.
- Hold `i_req` continuously with address 8'h00, then 8'h01. Required: two complete frames, no overlapping `o_tx_dv`, and the second request is accepted only after `o_busy` falls.
- Stub `i_tx_busy` held high for 50 cycles at the first SEND. Required: `o_tx_dv` stays 0 until busy drops, then pulses once with 8'h02.
- Assert `i_reset` during byte 3 of a frame. Required: next cycle `o_busy` = 0 and `o_req_ready` = 1, and no further `o_tx_dv`. A new request for 8'h05 then yields a full 6-byte frame.
- Overwrite the register on the cycle after LOAD. Required: the in-flight frame carries the old value.

Source files
------------

// File: rtl/reg_readback_tx_pkg.sv
// Shared types and constants for the register read-back sequencer.
package reg_readback_pkg;

    // Sequencer states:
    //   IDLE    | waiting for a read request, o_req_ready high
    //   READ    | read enable issued, counting out the register read latency
    //   LOAD    | capture {header, address, value} into the shift register
    //   SEND    | hand the top byte to uart_tx once it is not busy
    //   WAIT_HI | wait for uart_tx to raise busy (byte accepted)
    //   WAIT_LO | wait for uart_tx to drop busy, then advance to the next byte
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        LOAD    = 3'd2,
        SEND    = 3'd3,
        WAIT_HI = 3'd4,
        WAIT_LO = 3'd5
    } state_e;

    localparam logic [7:0] RESP_HEADER_DEFAULT = 8'h02;

    // Response frame: header byte, address byte, then the value bytes.
    function automatic int frame_len(input int value_words);
        return value_words + 2;
    endfunction

endpackage

// File: rtl/reg_readback_tx_if.sv
// Bundles the request, register read port and uart_tx handshake seen by the
// read-back sequencer. The sequencer uses the slave view; whatever drives the
// requests and models the register block / transmitter uses the master view.
interface reg_readback_tx_if #(
    parameter int WORD_WIDTH  = 8,
    parameter int VALUE_WORDS = 4
);
    // request side
    logic                              i_req;
    logic [WORD_WIDTH-1:0]             i_req_addr;
    logic                              o_req_ready;
    // register block read port
    logic                              o_r_en;
    logic [WORD_WIDTH-1:0]             o_r_addr;
    logic [WORD_WIDTH*VALUE_WORDS-1:0] i_r_data;
    // uart_tx side
    logic [WORD_WIDTH-1:0]             o_tx_data;
    logic                              o_tx_dv;
    logic                              i_tx_busy;
    // status
    logic                              o_busy;

    modport slave (
        input  i_req, i_req_addr, i_r_data, i_tx_busy,
        output o_req_ready, o_r_en, o_r_addr, o_tx_data, o_tx_dv, o_busy
    );

    modport master (
        output i_req, i_req_addr, i_r_data, i_tx_busy,
        input  o_req_ready, o_r_en, o_r_addr, o_tx_data, o_tx_dv, o_busy
    );

endinterface

// File: rtl/reg_readback_tx.sv
// Read-back sequencer: accepts a read request, issues one register read,
// captures the value and streams {header, address, value MSB first} through
// uart_tx one byte at a time. Every output comes straight from a flop.
module reg_readback_tx
    import reg_readback_pkg::*;
#(
    parameter int                    WORD_WIDTH   = 8,
    parameter int                    VALUE_WORDS  = 4,
    parameter int                    READ_LATENCY = 1,   // must be >= 1
    parameter logic [WORD_WIDTH-1:0] RESP_HEADER  = WORD_WIDTH'(RESP_HEADER_DEFAULT)
) (
    input  logic             clk,
    input  logic             i_reset,
    reg_readback_tx_if.slave bus
);

    localparam int FRAME_BYTES = frame_len(VALUE_WORDS);
    localparam int SHIFT_W     = WORD_WIDTH * FRAME_BYTES;
    localparam int CNT_W       = $clog2(VALUE_WORDS + 3);
    localparam int LAT_W       = $clog2(READ_LATENCY + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_BYTES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    state_e                state_q,     state_d;
    logic [WORD_WIDTH-1:0] addr_q,      addr_d;
    logic [LAT_W-1:0]      lat_q,       lat_d;
    logic [SHIFT_W-1:0]    shift_q,     shift_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  req_ready_q, req_ready_d;
    logic                  busy_q,      busy_d;
    logic                  r_en_q,      r_en_d;
    logic [WORD_WIDTH-1:0] r_addr_q,    r_addr_d;
    logic [WORD_WIDTH-1:0] tx_data_q,   tx_data_d;
    logic                  tx_dv_q,     tx_dv_d;

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so that they can be registered.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        lat_d     = lat_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        r_en_d    = 1'b0;
        r_addr_d  = r_addr_q;
        tx_dv_d   = 1'b0;
        tx_data_d = tx_data_q;

        unique case (state_q)
            IDLE: begin
                if (bus.i_req && req_ready_q) begin
                    addr_d   = bus.i_req_addr;
                    r_en_d   = 1'b1;
                    r_addr_d = bus.i_req_addr;
                    lat_d    = LAT_LOAD;
                    state_d  = READ;
                end
            end
            READ: begin
                lat_d = lat_q - LAT_ONE;
                if (lat_q == LAT_ONE) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Only sampling point of the register value; later writes to
                // the register cannot disturb the frame in flight.
                shift_d = {RESP_HEADER, addr_q, bus.i_r_data};
                cnt_d   = CNT_LOAD;
                state_d = SEND;
            end
            SEND: begin
                if (!bus.i_tx_busy) begin
                    tx_dv_d   = 1'b1;
                    tx_data_d = shift_q[SHIFT_W-1 -: WORD_WIDTH];
                    state_d   = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (bus.i_tx_busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!bus.i_tx_busy) begin
                    shift_d = shift_q << WORD_WIDTH;
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = (cnt_q == CNT_ONE) ? IDLE : SEND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags follow the state being entered so they line up with it.
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers; reset wins over any request on the same edge.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            lat_q       <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            r_en_q      <= 1'b0;
            r_addr_q    <= '0;
            tx_data_q   <= '0;
            tx_dv_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            lat_q       <= lat_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            r_en_q      <= r_en_d;
            r_addr_q    <= r_addr_d;
            tx_data_q   <= tx_data_d;
            tx_dv_q     <= tx_dv_d;
        end
    end

    assign bus.o_req_ready = req_ready_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_r_en      = r_en_q;
    assign bus.o_r_addr    = r_addr_q;
    assign bus.o_tx_data   = tx_data_q;
    assign bus.o_tx_dv     = tx_dv_q;

endmodule

// File: tb/tb_reg_readback_tx.sv
// Directed bench for reg_readback_tx: one instance with READ_LATENCY = 1
// against a live register-array stub, one with READ_LATENCY = 2 against a
// stub whose data is valid in a single cycle only.
module tb_reg_readback_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_readback_tx_if #(.WORD_WIDTH(8), .VALUE_WORDS(4)) bus  ();
    reg_readback_tx_if #(.WORD_WIDTH(8), .VALUE_WORDS(4)) bus2 ();

    reg_readback_tx #(
        .WORD_WIDTH(8), .VALUE_WORDS(4), .READ_LATENCY(1), .RESP_HEADER(8'h02)
    ) u_dut (
        .clk(clk), .i_reset(rst), .bus(bus)
    );

    reg_readback_tx #(
        .WORD_WIDTH(8), .VALUE_WORDS(4), .READ_LATENCY(2), .RESP_HEADER(8'h02)
    ) u_dut2 (
        .clk(clk), .i_reset(rst), .bus(bus2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- stubs and monitors for the READ_LATENCY = 1 instance
    logic [31:0] mem [256];
    logic [7:0]  rd_addr_q    = 8'h00;
    logic        hold_busy    = 1'b0;
    int          tx_cnt       = 0;
    int          cyc          = 0;
    int          r_en_cnt     = 0;
    int          r_en_cyc     = 0;
    int          dv_busy_err  = 0;
    int          dv_overlap   = 0;
    int          acc_cnt      = 0;
    int          acc_busy_err = 0;
    logic        dv_prev      = 1'b0;
    logic [7:0]  tx_q [$];
    int          dv_cyc_q [$];

    assign bus.i_r_data  = mem[rd_addr_q];
    assign bus.i_tx_busy = hold_busy || (tx_cnt != 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.o_r_en) begin
            r_en_cnt  <= r_en_cnt + 1;
            r_en_cyc  <= cyc;
            rd_addr_q <= bus.o_r_addr;
        end
        if (bus.o_tx_dv) begin
            tx_q.push_back(bus.o_tx_data);
            dv_cyc_q.push_back(cyc);
            if (bus.i_tx_busy) dv_busy_err <= dv_busy_err + 1;
            if (dv_prev)       dv_overlap  <= dv_overlap + 1;
            tx_cnt <= 4;
        end else if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 1;
        end
        dv_prev <= bus.o_tx_dv;
        if (!rst && bus.i_req && bus.o_req_ready) begin
            acc_cnt <= acc_cnt + 1;
            if (bus.o_busy) acc_busy_err <= acc_busy_err + 1;
        end
    end

    // ---------------- stubs and monitors for the READ_LATENCY = 2 instance
    logic       v1 = 1'b0, v2 = 1'b0;
    logic [7:0] a1 = 8'h00, a2 = 8'h00;
    int         tx_cnt2   = 0;
    int         r_en_cyc2 = 0;
    logic [7:0] tx_q2 [$];
    int         dv_cyc_q2 [$];

    assign bus2.i_r_data  = (v2 && a2 == 8'hff) ? 32'h12345678 : 32'hdeadbeef;
    assign bus2.i_tx_busy = (tx_cnt2 != 0);

    always @(posedge clk) begin
        v1 <= bus2.o_r_en;
        v2 <= v1;
        a1 <= bus2.o_r_addr;
        a2 <= a1;
        if (bus2.o_r_en) r_en_cyc2 <= cyc;
        if (bus2.o_tx_dv) begin
            tx_q2.push_back(bus2.o_tx_data);
            dv_cyc_q2.push_back(cyc);
            tx_cnt2 <= 3;
        end else if (tx_cnt2 != 0) begin
            tx_cnt2 <= tx_cnt2 - 1;
        end
    end

    // ---------------- helpers (called at a negedge, return at a negedge)
    task automatic send_req(input logic [7:0] a);
        bit ok;
        ok = 1'b0;
        bus.i_req      = 1'b1;
        bus.i_req_addr = a;
        for (int k = 0; k < 1000; k++) begin
            if (bus.o_req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_vec("req_accept", ok, 1);
        @(negedge clk);
        bus.i_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (bus.o_busy && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_vec({tag, "_idle"}, bus.o_busy, 0);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] q [$], input int base,
                               input logic [47:0] exp);
        logic [7:0] e;
        logic [7:0] g;
        for (int k = 0; k < 6; k++) begin
            e = exp[47-8*k -: 8];
            g = (base + k < q.size()) ? q[base + k] : 8'hxx;
            check_vec($sformatf("%s_byte%0d", tag, k), g, e);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base, i, ren0, a0;
        bus.i_req       = 1'b0;
        bus.i_req_addr  = 8'h00;
        bus2.i_req      = 1'b0;
        bus2.i_req_addr = 8'h00;
        for (int k = 0; k < 256; k++) mem[k] = 32'h0;
        mem[8'h00] = 32'ha0a1a2a3;
        mem[8'h01] = 32'hb0b1b2b3;
        mem[8'h05] = 32'h05060708;
        mem[8'h33] = 32'h33333333;
        mem[8'h44] = 32'h11223344;

        // reset state
        repeat (3) @(negedge clk);
        check_vec("rst_ready",   bus.o_req_ready, 1);
        check_vec("rst_busy",    bus.o_busy,      0);
        check_vec("rst_r_en",    bus.o_r_en,      0);
        check_vec("rst_tx_dv",   bus.o_tx_dv,     0);
        check_vec("rst_tx_data", bus.o_tx_data,   0);
        check_vec("rst_r_addr",  bus.o_r_addr,    0);
        check_vec("rst_ready2",  bus2.o_req_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // write-then-read of address 12
        mem[8'h12] = 32'hbbb00b00;
        base = tx_q.size();
        ren0 = r_en_cnt;
        send_req(8'h12);
        check_vec("t1_r_en",      bus.o_r_en,      1);
        check_vec("t1_r_addr",    bus.o_r_addr,    8'h12);
        check_vec("t1_ready_low", bus.o_req_ready, 0);
        check_vec("t1_busy_high", bus.o_busy,      1);
        @(negedge clk);
        check_vec("t1_r_en_pulse", bus.o_r_en,     0);
        wait_idle("t1");
        check_vec("t1_ready_back", bus.o_req_ready, 1);
        check_vec("t1_len", tx_q.size() - base, 6);
        check_frame("t1", tx_q, base, 48'h0212bbb00b00);
        check_vec("t1_r_en_once", r_en_cnt - ren0, 1);
        check_vec("t1_first_dv",
                  (dv_cyc_q.size() > base) ? dv_cyc_q[base] - r_en_cyc : -1, 3);

        // READ_LATENCY = 2 instance, data valid on one cycle only
        base = tx_q2.size();
        bus2.i_req      = 1'b1;
        bus2.i_req_addr = 8'hff;
        @(negedge clk);
        bus2.i_req = 1'b0;
        check_vec("t2_r_en", bus2.o_r_en, 1);
        i = 0;
        while (bus2.o_busy && i < 2000) begin
            @(negedge clk);
            i++;
        end
        check_vec("t2_idle", bus2.o_busy, 0);
        check_vec("t2_len", tx_q2.size() - base, 6);
        check_frame("t2", tx_q2, base, 48'h02ff12345678);
        check_vec("t2_first_dv",
                  (dv_cyc_q2.size() > base) ? dv_cyc_q2[base] - r_en_cyc2 : -1, 4);

        // request held high across two frames
        base = tx_q.size();
        a0   = acc_cnt;
        bus.i_req      = 1'b1;
        bus.i_req_addr = 8'h00;
        i = 0;
        while (acc_cnt == a0 && i < 100) begin
            @(negedge clk);
            i++;
        end
        check_vec("t3_acc1", acc_cnt - a0, 1);
        bus.i_req_addr = 8'h01;
        i = 0;
        while (acc_cnt == a0 + 1 && i < 2000) begin
            @(negedge clk);
            i++;
        end
        check_vec("t3_acc2", acc_cnt - a0, 2);
        bus.i_req = 1'b0;
        wait_idle("t3");
        check_vec("t3_len", tx_q.size() - base, 12);
        check_frame("t3a", tx_q, base,     48'h0200a0a1a2a3);
        check_frame("t3b", tx_q, base + 6, 48'h0201b0b1b2b3);

        // transmitter busy for 50 cycles at the first SEND
        base = tx_q.size();
        hold_busy = 1'b1;
        send_req(8'h05);
        repeat (50) @(negedge clk);
        check_vec("t4_no_dv", tx_q.size() - base, 0);
        check_vec("t4_busy",  bus.o_busy, 1);
        hold_busy = 1'b0;
        wait_idle("t4");
        check_vec("t4_len", tx_q.size() - base, 6);
        check_frame("t4", tx_q, base, 48'h020505060708);

        // reset beats a simultaneous request
        bus.i_req      = 1'b1;
        bus.i_req_addr = 8'h05;
        rst            = 1'b1;
        @(negedge clk);
        check_vec("t5_prio_busy", bus.o_busy, 0);
        check_vec("t5_prio_r_en", bus.o_r_en, 0);
        bus.i_req = 1'b0;
        rst       = 1'b0;
        @(negedge clk);

        // reset during byte 3
        base = tx_q.size();
        send_req(8'h33);
        i = 0;
        while (tx_q.size() < base + 3 && i < 500) begin
            @(negedge clk);
            i++;
        end
        check_vec("t5_three", tx_q.size() - base, 3);
        rst = 1'b1;
        @(negedge clk);
        check_vec("t5_busy",  bus.o_busy,      0);
        check_vec("t5_ready", bus.o_req_ready, 1);
        check_vec("t5_dv",    bus.o_tx_dv,     0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check_vec("t5_no_more", tx_q.size() - base, 3);
        base = tx_q.size();
        send_req(8'h05);
        wait_idle("t5b");
        check_vec("t5b_len", tx_q.size() - base, 6);
        check_frame("t5b", tx_q, base, 48'h020505060708);

        // register overwritten the cycle after LOAD
        base = tx_q.size();
        send_req(8'h44);
        @(negedge clk);
        @(negedge clk);
        mem[8'h44] = 32'hcafef00d;
        wait_idle("t6");
        check_vec("t6_len", tx_q.size() - base, 6);
        check_frame("t6", tx_q, base, 48'h024411223344);
        base = tx_q.size();
        send_req(8'h44);
        wait_idle("t6b");
        check_frame("t6b", tx_q, base, 48'h0244cafef00d);

        // handshake invariants over the whole run
        check_vec("dv_while_busy",   dv_busy_err,  0);
        check_vec("dv_overlap",      dv_overlap,   0);
        check_vec("accept_while_busy", acc_busy_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
